lab9_soc_multi_timer: RTL and testbench
=======================================

# lab9_soc_multi_timer

Parametrised multi-channel Avalon-MM interval timer for the lab SoC. It replaces the single fixed 32-bit timer peripheral with NUM_CH independent down-counters of configurable width. Each channel has a programmable 8-bit prescaler, one-shot or continuous mode, a counter snapshot and its own interrupt. The block sits on the Nios II data bus as one slave and drives a per-channel IRQ vector plus a combined IRQ line.

## Interface
- NUM_CH, 2, number of timer channels; legal values 1, 2, 4, 8.
- CNT_W, 32, counter/period width in bits; legal range 8..32.
- RESET_PERIOD, 49999, reset value of every channel's period and counter.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  log2(NUM_CH)+2  word address, split as {channel, reg[1:0]}.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- irq_vec  out  NUM_CH  per-channel interrupt; bit i = TO[i] & ITO[i].
- irq  out  1  OR-reduction of irq_vec.

## Operation
- Register map per channel, selected by reg[1:0]:
  - 0 STATUS: read {30'b0, RUN, TO}. Any write clears TO.
  - 1 CONTROL: write bit0 ITO, bit1 CONT, bit2 START (pulse), bit3 STOP (pulse), bits[15:8] PRESC. Read returns {16'b0, PRESC, 4'b0, 2'b00, CONT, ITO}; START/STOP read as 0.
  - 2 PERIOD: read/write, CNT_W bits, zero-extended on read, upper writedata bits ignored.
  - 3 SNAPSHOT: any write copies the current counter into the snapshot; a read returns the snapshot.
- Reset values: counter=period=RESET_PERIOD, snapshot=0, PRESC=0, ITO=CONT=TO=RUN=0, presc_cnt=0, readdata=0, irq_vec=0, irq=0.
- Prescaler: presc_cnt counts down. A tick occurs when RUN=1 and presc_cnt==0, and presc_cnt then reloads PRESC. PRESC=0 gives a tick every clk. A tick occurs every PRESC+1 clocks.
- On a tick:
  - If counter==0: counter<=period, TO<=1, and RUN<=0 when CONT=0.
  - Otherwise: counter<=counter-1.
  - Timeout interval is (period+1)*(PRESC+1) clocks.
- START: RUN<=1 and presc_cnt<=PRESC. The counter is not reloaded; it resumes from its current value.
- STOP: RUN<=0. The counter and TO hold their values.
- PERIOD write:
  - period<=data.
  - counter<=data on the following clk (one-cycle forced-reload flag).
  - RUN<=0 and presc_cnt<=PRESC.
- Channels are fully independent; a write affects only the addressed channel.

## Timing
- Writes take effect at the clk edge on which the write is presented. The PERIOD-write counter reload happens one edge later.
- Reads have a fixed latency of 1: readdata is valid on the edge after address and chipselect are presented. readdata updates every cycle from address, regardless of chipselect.
- An irq_vec bit rises on the same edge that TO sets, and falls on the same edge as a STATUS write or an ITO clear.
- Simultaneous events:
  - START and STOP in the same write: START wins.
  - STATUS write and timeout on the same edge: TO=1, so the event is not lost.
  - PERIOD write and tick on the same edge: the period write wins; no TO set and no decrement.
  - CONTROL write with START on the forced-reload edge: the counter reloads and RUN=1.
  - SNAPSHOT write on a decrement edge: captures the pre-decrement value.
- Counter wrap: the counter never underflows; the zero-reload path is the only exit from 0. Period=0 in continuous mode with PRESC=0 gives TO every clk.
- Reset mid-count: all state returns to reset values immediately (asynchronous). The counter restarts only after a START.

## Test plan
- Reset then read ch0 PERIOD -> 49999. Read ch0 STATUS -> 0. irq=0.
- Ch0 setup: write PERIOD=4, CONTROL=0x7 (ITO, CONT, START). -> First TO and irq_vec[0] rise 5 clk after the START edge. A STATUS write clears TO. The next TO comes 5 clk after the previous one. RUN stays 1.
- Ch1 one-shot with prescaler: PERIOD=2, CONTROL=0x0305 (PRESC=3, ITO, START, one-shot). -> TO at 12 clk. RUN=0 afterwards. The counter holds 2. irq_vec=2'b10 and irq=1.
- Ch0 running at counter=100: write SNAPSHOT, then read SNAPSHOT -> 100. Write PERIOD=50 -> RUN=0 and counter reads 50 via snapshot. A START resumes counting from 50.
- Ch0 with PERIOD=0, PRESC=0, CONT=1: issue a STATUS write on the same edge as a timeout -> TO remains 1.
- Ch0 running: write CONTROL=0x0C (START and STOP) -> RUN=1. Assert reset_n=0 mid-count -> readdata, irq and RUN go to 0 without a clock edge.

Source files
------------

// File: rtl/lab9_soc_multi_timer_if.sv
// Avalon-MM slave port bundle for the multi-channel timer.
// address is {channel, reg[1:0]}; readdata is returned by the slave one cycle after the address is presented.
interface lab9_soc_multi_timer_if #(
  parameter int AW = 3
) ();
  logic [AW-1:0] address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/lab9_soc_multi_timer.sv
// NUM_CH independent prescaled down-counter timers with per-channel IRQ; writes act on the presented edge,
// reads return registered data one cycle later; the slave never stalls the bus.
module lab9_soc_multi_timer #(
  parameter int NUM_CH       = 2,
  parameter int CNT_W        = 32,
  parameter int RESET_PERIOD = 49999
) (
  input  logic                   clk,
  input  logic                   reset_n,
  lab9_soc_multi_timer_if.slave  avs,
  output logic [NUM_CH-1:0]      irq_vec,
  output logic                   irq
);
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int AW  = $clog2(NUM_CH) + 2;
  localparam logic [CNT_W-1:0] RST_CNT = CNT_W'(RESET_PERIOD);

  logic [CHW-1:0] ch_sel;
  logic [1:0]     reg_sel;
  logic           wr_en, start_w, stop_w;

  logic [CNT_W-1:0] cnt_q [NUM_CH], cnt_d [NUM_CH];
  logic [CNT_W-1:0] per_q [NUM_CH], per_d [NUM_CH];
  logic [CNT_W-1:0] snap_q[NUM_CH], snap_d[NUM_CH];
  logic [7:0]       presc_q[NUM_CH], presc_d[NUM_CH];
  logic [7:0]       pcnt_q [NUM_CH], pcnt_d [NUM_CH];
  logic [NUM_CH-1:0] ito_q, ito_d, cont_q, cont_d, to_q, to_d, run_q, run_d, rld_q, rld_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [NUM_CH-1:0] wr_stat, wr_ctrl, wr_per, wr_snap;
  logic [NUM_CH-1:0] pz, cz, hold, adv, tmo;

  generate
    if (NUM_CH > 1) begin : g_multi
      assign ch_sel = avs.address[AW-1:2];
    end else begin : g_single
      assign ch_sel = '0;
    end
  endgenerate

  assign reg_sel = avs.address[1:0];
  assign wr_en   = avs.chipselect && !avs.write_n;
  assign start_w = avs.writedata[2];
  assign stop_w  = avs.writedata[3];

  always_comb begin
    wr_stat = '0;
    wr_ctrl = '0;
    wr_per  = '0;
    wr_snap = '0;
    pz      = '0;
    cz      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pz[i] = (pcnt_q[i] == 8'd0);
      cz[i] = (cnt_q[i] == '0);
      if (wr_en && (ch_sel == CHW'(i))) begin
        case (reg_sel)
          2'd0:    wr_stat[i] = 1'b1;
          2'd1:    wr_ctrl[i] = 1'b1;
          2'd2:    wr_per[i]  = 1'b1;
          default: wr_snap[i] = 1'b1;
        endcase
      end
    end
  end

  // A PERIOD write, or a pure STOP, freezes the channel on that edge.
  assign hold = wr_per | (wr_ctrl & {NUM_CH{stop_w & ~start_w}});
  assign adv  = run_q & pz & ~hold & ~rld_q;
  assign tmo  = adv & cz;

  always_comb begin
    cnt_d   = cnt_q;
    per_d   = per_q;
    snap_d  = snap_q;
    presc_d = presc_q;
    pcnt_d  = pcnt_q;
    ito_d   = ito_q;
    cont_d  = cont_q;
    to_d    = to_q;
    run_d   = run_q;
    rld_d   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (run_q[i] && !hold[i])
        pcnt_d[i] = pz[i] ? presc_q[i] : pcnt_q[i] - 8'd1;

      if (rld_q[i]) begin
        cnt_d[i] = per_q[i];
      end else if (adv[i]) begin
        if (cz[i]) begin
          cnt_d[i] = per_q[i];
          to_d[i]  = 1'b1;
          if (!cont_q[i]) run_d[i] = 1'b0;
        end else begin
          cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end
      end

      // A timeout on the clearing edge must survive the clear.
      if (wr_stat[i]) to_d[i] = tmo[i];

      if (wr_ctrl[i]) begin
        ito_d[i]   = avs.writedata[0];
        cont_d[i]  = avs.writedata[1];
        presc_d[i] = avs.writedata[15:8];
        if (start_w) begin
          run_d[i]  = 1'b1;
          pcnt_d[i] = avs.writedata[15:8];
        end else if (stop_w) begin
          run_d[i] = 1'b0;
        end
      end

      if (wr_per[i]) begin
        per_d[i]  = avs.writedata[CNT_W-1:0];
        rld_d[i]  = 1'b1;
        run_d[i]  = 1'b0;
        pcnt_d[i] = presc_q[i];
      end

      if (wr_snap[i]) snap_d[i] = cnt_q[i];
    end
  end

  always_comb begin
    rdata_d = '0;
    case (reg_sel)
      2'd0:    rdata_d = {30'b0, run_q[ch_sel], to_q[ch_sel]};
      2'd1:    rdata_d = {16'b0, presc_q[ch_sel], 6'b0, cont_q[ch_sel], ito_q[ch_sel]};
      2'd2:    rdata_d = 32'(per_q[ch_sel]);
      default: rdata_d = 32'(snap_q[ch_sel]);
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '{default: RST_CNT};
      per_q   <= '{default: RST_CNT};
      snap_q  <= '{default: '0};
      presc_q <= '{default: 8'd0};
      pcnt_q  <= '{default: 8'd0};
      ito_q   <= '0;
      cont_q  <= '0;
      to_q    <= '0;
      run_q   <= '0;
      rld_q   <= '0;
      rdata_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      snap_q  <= snap_d;
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
      ito_q   <= ito_d;
      cont_q  <= cont_d;
      to_q    <= to_d;
      run_q   <= run_d;
      rld_q   <= rld_d;
      rdata_q <= rdata_d;
    end
  end

  assign avs.readdata = rdata_q;
  assign irq_vec      = to_q & ito_q;
  assign irq          = |irq_vec;
endmodule

// File: tb/tb_lab9_soc_multi_timer.sv
// Directed bench for lab9_soc_multi_timer: reads push expected data into a scoreboard queue,
// a monitor pops and compares one cycle after each read is presented.
module tb_lab9_soc_multi_timer;
  localparam int NUM_CH = 2;
  localparam int AW     = 3;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic [NUM_CH-1:0] irq_vec;
  logic              irq;
  logic              rd_flag = 1'b0;

  exp_t sb[$];
  int   nvec = 0;
  int   nerr = 0;

  lab9_soc_multi_timer_if #(.AW(AW)) bus ();

  lab9_soc_multi_timer #(
    .NUM_CH(NUM_CH), .CNT_W(32), .RESET_PERIOD(49999)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .avs     (bus),
    .irq_vec (irq_vec),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Each bus task spans exactly one rising edge, at which the access takes effect.
  task automatic wr(input int ch, input int r, input logic [31:0] d);
    #1;
    bus.address    = AW'(ch * 4 + r);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = d;
    @(posedge clk);
  endtask

  task automatic rd(input int ch, input int r, input logic [31:0] exp, input string name);
    exp_t e;
    #1;
    bus.address    = AW'(ch * 4 + r);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    e.name = name;
    e.exp  = exp;
    sb.push_back(e);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      #1;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      @(posedge clk);
    end
  endtask

  always @(posedge clk) rd_flag <= bus.chipselect && bus.write_n;

  always @(negedge clk) begin
    exp_t e;
    if (rd_flag) begin
      if (sb.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_read: got 0x%08h, expected no read data", bus.readdata);
      end else begin
        e = sb.pop_front();
        check(e.name, bus.readdata, e.exp);
      end
    end
  end

  initial begin
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;

    // Reset state
    #1 reset_n = 1'b0;
    #2;
    check("rst_readdata", bus.readdata, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    rd(0, 2, 32'd49999, "rst_period");
    rd(0, 0, 32'd0, "rst_status");
    #1 check("rst_irq_vec", {30'b0, irq_vec}, 32'd0);

    // Ch0 continuous, period 4: TO every 5 clk
    wr(0, 2, 32'd4);
    wr(0, 1, 32'h7);
    idle(3);
    rd(0, 0, 32'd2, "c0_pre_to_a");
    #1 check("c0_irq_before", {30'b0, irq_vec}, 32'd0);
    rd(0, 0, 32'd2, "c0_pre_to_b");
    #1 check("c0_irq_at_to", {30'b0, irq_vec}, 32'd1);
    rd(0, 0, 32'd3, "c0_first_to");
    wr(0, 0, 32'd0);
    rd(0, 0, 32'd2, "c0_to_cleared");
    idle(1);
    rd(0, 0, 32'd2, "c0_pre_to2");
    rd(0, 0, 32'd3, "c0_second_to");
    wr(0, 1, 32'h8);
    wr(0, 0, 32'd0);
    #1 check("c0_quiet_irq", {31'b0, irq}, 32'd0);

    // Ch1 one-shot, period 2, presc 3: TO after 12 clk
    wr(1, 2, 32'd2);
    wr(1, 1, 32'h0305);
    idle(10);
    rd(1, 0, 32'd2, "c1_run_a");
    rd(1, 0, 32'd2, "c1_run_b");
    rd(1, 0, 32'd1, "c1_oneshot_to");
    #1 check("c1_irq_vec", {30'b0, irq_vec}, 32'h2);
    check("c1_irq", {31'b0, irq}, 32'd1);
    wr(1, 3, 32'd0);
    rd(1, 3, 32'd2, "c1_cnt_hold");
    rd(1, 1, 32'h0301, "c1_ctrl_read");
    wr(1, 1, 32'h0);
    #1 check("c1_ito_clr_irq", {31'b0, irq}, 32'd0);

    // Ch0 snapshot, period rewrite while running, resume
    wr(0, 2, 32'd100);
    wr(0, 1, 32'h6);
    wr(0, 3, 32'd0);
    rd(0, 3, 32'd100, "c0_snap_100");
    wr(0, 2, 32'd50);
    rd(0, 0, 32'd0, "c0_per_stops");
    wr(0, 3, 32'd0);
    rd(0, 3, 32'd50, "c0_snap_reload");
    wr(0, 1, 32'h6);
    idle(1);
    wr(0, 3, 32'd0);
    rd(0, 3, 32'd49, "c0_resume");
    wr(0, 1, 32'h8);
    idle(2);
    wr(0, 3, 32'd0);
    rd(0, 3, 32'd47, "c0_stop_hold");

    // Period 0: STATUS write colliding with a timeout keeps TO
    wr(0, 2, 32'd0);
    wr(0, 1, 32'h7);
    idle(1);
    wr(0, 0, 32'd0);
    rd(0, 0, 32'd3, "c0_to_not_lost");
    #1 check("c0_p0_irq_vec", {30'b0, irq_vec}, 32'h1);

    // START+STOP together, then asynchronous reset mid-count
    wr(0, 2, 32'd1000);
    wr(0, 0, 32'd0);
    wr(1, 1, 32'h1);
    wr(0, 1, 32'h0C);
    rd(0, 0, 32'd2, "c0_start_wins");
    idle(1);
    #1;
    check("pre_rst_readdata", bus.readdata, 32'd2);
    check("pre_rst_irq_vec", {30'b0, irq_vec}, 32'h2);
    #1 reset_n = 1'b0;
    #1;
    check("async_rst_readdata", bus.readdata, 32'd0);
    check("async_rst_irq", {31'b0, irq}, 32'd0);
    check("async_rst_irq_vec", {30'b0, irq_vec}, 32'd0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    rd(0, 0, 32'd0, "post_rst_status");
    rd(0, 2, 32'd49999, "post_rst_period");
    rd(1, 1, 32'd0, "post_rst_ctrl1");
    idle(3);
    rd(0, 0, 32'd0, "post_rst_no_run");
    rd(0, 3, 32'd0, "post_rst_snap");
    idle(2);
    #1 check("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
